// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: ALU opcodes, flag bit positions and the
// MUL/DIV sequencer command and state encodings.
package cpu_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_MULH = 2'b01,
        MD_DIV  = 2'b10,
        MD_REM  = 2'b11
    } md_cmd_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_ITER,
        MD_DONE
    } md_state_e;

    // Upper words (product high half, remainder) live in acc, lower ones in mq.
    function automatic logic [31:0] md_pick(input md_cmd_e c, input logic [31:0] hi,
                                            input logic [31:0] lo);
        return (c == MD_MULH || c == MD_REM) ? hi : lo;
    endfunction

    function automatic logic [7:0] md_flags(input logic [3:0] upper, input logic [31:0] res,
                                            input logic ovf);
        logic [7:0] f;
        f         = '0;
        f[7:4]    = upper;
        f[FLAG_Z] = (res == '0);
        f[FLAG_N] = res[31];
        f[FLAG_V] = ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MUL/DIV sequencer that borrows the execute-stage ALU one
// pass per granted cycle (shift-add multiply, restoring divide).
module alu_muldiv_seq
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      cmd,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [7:0]      flags_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [7:0]      flags_out,
    output logic            div_by_zero,
    output logic            alu_req,
    input  logic            alu_gnt,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_carry
);

    localparam logic [XLEN-1:0] ALL_ONES = '1;

    md_state_e       state, state_nxt;
    md_cmd_e         cmd_q;
    md_cmd_e         cmd_in;
    logic [XLEN-1:0] acc, acc_nxt;
    logic [XLEN-1:0] mq, mq_nxt;
    logic [XLEN-1:0] divisor;
    logic [5:0]      cnt;
    logic [3:0]      flags_hi;
    logic            accept, div_zero_req, last_pass, qbit;
    logic [XLEN-1:0] div_a, div0_res, fin_res;
    logic            fin_ovf;
    logic            unused_flags;

    assign unused_flags = ^flags_in[3:0];

    assign cmd_in       = md_cmd_e'(cmd);
    assign accept       = (state == MD_IDLE) && start;
    assign div_zero_req = accept && cmd_in[1] && (op_b == '0);
    assign last_pass    = (cnt == 6'(ITERS - 1));
    assign div_a        = {acc[XLEN-2:0], mq[XLEN-1]};
    // A set top bit means the shifted partial remainder already exceeds any divisor.
    assign qbit         = acc[XLEN-1] | ~alu_carry;
    assign busy         = (state != MD_IDLE);
    assign done         = (state == MD_DONE);
    assign div0_res     = md_pick(cmd_in, op_a, ALL_ONES);
    assign fin_res      = md_pick(cmd_q, acc_nxt, mq_nxt);
    assign fin_ovf      = (cmd_q == MD_MUL) && (acc_nxt != '0);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        mq_nxt    = mq;
        alu_req   = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = ALU_ADD;
        case (state)
            MD_IDLE: begin
                if (start) state_nxt = div_zero_req ? MD_DONE : MD_ITER;
            end
            MD_ITER: begin
                alu_req = 1'b1;
                if (cmd_q[1]) begin
                    alu_a  = div_a;
                    alu_b  = divisor;
                    alu_op = ALU_SUB;
                    if (alu_gnt) begin
                        acc_nxt = qbit ? alu_result : div_a;
                        mq_nxt  = {mq[XLEN-2:0], qbit};
                    end
                end else begin
                    alu_a = acc;
                    alu_b = mq[0] ? divisor : '0;
                    if (alu_gnt) {acc_nxt, mq_nxt} = {alu_carry, alu_result, mq[XLEN-1:1]};
                end
                if (alu_gnt && last_pass) state_nxt = MD_DONE;
            end
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MD_IDLE;
            cmd_q       <= MD_MUL;
            acc         <= '0;
            mq          <= '0;
            divisor     <= '0;
            cnt         <= '0;
            flags_hi    <= '0;
            result      <= '0;
            flags_out   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            mq    <= mq_nxt;
            if (accept) begin
                cmd_q    <= cmd_in;
                divisor  <= op_b;
                flags_hi <= flags_in[7:4];
                acc      <= '0;
                mq       <= op_a;
                cnt      <= '0;
                if (div_zero_req) begin
                    result      <= div0_res;
                    flags_out   <= md_flags(flags_in[7:4], div0_res, 1'b1);
                    div_by_zero <= 1'b1;
                end
            end
            if (state == MD_ITER && alu_gnt) begin
                cnt <= cnt + 6'd1;
                if (last_pass) begin
                    result      <= fin_res;
                    flags_out   <= md_flags(flags_hi, fin_res, fin_ovf);
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: behavioural ALU behind a grant mux,
// arithmetic reference model, directed and randomized operations.
module tb_alu_muldiv_seq;

    localparam logic [1:0] C_MUL  = 2'd0;
    localparam logic [1:0] C_MULH = 2'd1;
    localparam logic [1:0] C_DIV  = 2'd2;
    localparam logic [1:0] C_REM  = 2'd3;

    logic        clk, rst_n, start, busy, done, div_by_zero, alu_req, alu_gnt, alu_carry;
    logic [1:0]  cmd;
    logic [31:0] op_a, op_b, result, alu_a, alu_b, alu_result;
    logic [7:0]  flags_in, flags_out;
    logic [3:0]  alu_op;

    logic [31:0] core_a, core_b, mux_a, mux_b;
    logic [3:0]  mux_op;

    int checks = 0;
    int errors = 0;

    alu_muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .op_a(op_a), .op_b(op_b),
        .flags_in(flags_in), .busy(busy), .done(done), .result(result),
        .flags_out(flags_out), .div_by_zero(div_by_zero), .alu_req(alu_req),
        .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The core owns the ALU whenever the sequencer is not granted.
    assign mux_a  = alu_gnt ? alu_a  : core_a;
    assign mux_b  = alu_gnt ? alu_b  : core_b;
    assign mux_op = alu_gnt ? alu_op : 4'h0;

    always_comb begin
        alu_result = 32'd0;
        alu_carry  = 1'b0;
        if (mux_op == 4'h1) begin
            alu_result = mux_a - mux_b;
            alu_carry  = (mux_a < mux_b);
        end else begin
            {alu_carry, alu_result} = {1'b0, mux_a} + {1'b0, mux_b};
        end
    end

    function automatic void ref_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] fu, output logic [31:0] r,
                                   output logic [7:0] f, output logic dz);
        logic [63:0] p;
        logic        v;
        p  = {32'd0, a} * {32'd0, b};
        dz = 1'b0;
        v  = 1'b0;
        case (c)
            C_MUL:  begin r = p[31:0];  v = (p[63:32] != 32'd0); end
            C_MULH: r = p[63:32];
            C_DIV:  if (b == 0) begin r = 32'hFFFF_FFFF; v = 1'b1; dz = 1'b1; end else r = a / b;
            default: if (b == 0) begin r = a; v = 1'b1; dz = 1'b1; end else r = a % b;
        endcase
        f = {fu, v, r[31], (r == 32'd0), 1'b0};
    endfunction

    task automatic do_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] fu, input int gnt_pct, input bit noisy,
                         output logic [31:0] r, output logic [7:0] f, output logic dz,
                         output int edges, output int passes, output logic busy_after,
                         output bit timeout);
        edges   = 0;
        passes  = 0;
        timeout = 1'b0;
        @(negedge clk);
        cmd      = c;
        op_a     = a;
        op_b     = b;
        flags_in = {fu, 4'($urandom)};
        start    = 1'b1;
        alu_gnt  = 1'b0;
        forever begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            core_a = $urandom;
            core_b = $urandom;
            if (done) break;
            if (edges > 400) begin timeout = 1'b1; break; end
            start = noisy ? 1'($urandom_range(1)) : 1'b0;
            if (noisy) begin
                cmd  = 2'($urandom);
                op_a = $urandom;
                op_b = $urandom;
            end
            alu_gnt = ($urandom_range(99) < gnt_pct);
            if (alu_req && alu_gnt) passes++;
        end
        r  = result;
        f  = flags_out;
        dz = div_by_zero;
        // A start held during the DONE cycle must not launch a new operation.
        start   = noisy;
        alu_gnt = 1'b0;
        @(negedge clk);
        start      = 1'b0;
        busy_after = busy;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero, alu_req} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0000", {busy, done, div_by_zero, alu_req});
        end
        checks++;
        if (result !== 32'd0 || flags_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%h exp 0/0", result, flags_out);
        end
        checks++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 4'h0) begin
            errors++;
            $display("FAIL reset_alu got %h/%h/%h exp 0/0/0", alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_mul_basic();
        logic [31:0] r, er;
        logic [7:0]  f, ef;
        logic        dz, edz, ba;
        int          ed, ps;
        bit          to;
        do_op(C_MUL, 32'd7, 32'd6, 4'h5, 100, 1'b0, r, f, dz, ed, ps, ba, to);
        ref_op(C_MUL, 32'd7, 32'd6, 4'h5, er, ef, edz);
        checks++;
        if (to) begin errors++; $display("FAIL mul7x6_timeout got timeout exp done"); end
        checks++;
        if (r !== er || r !== 32'd42) begin errors++; $display("FAIL mul7x6_result got %h exp %h", r, er); end
        checks++;
        if (f !== ef) begin errors++; $display("FAIL mul7x6_flags got %h exp %h", f, ef); end
        checks++;
        if (ed !== 33) begin errors++; $display("FAIL mul7x6_latency got %0d edges exp 33", ed); end
        checks++;
        if (ps !== 32) begin errors++; $display("FAIL mul7x6_passes got %0d exp 32", ps); end
        checks++;
        if (ba !== 1'b0) begin errors++; $display("FAIL mul7x6_idle_after got busy=%b exp 0", ba); end
    endtask

    task automatic test_directed();
        logic [1:0]  cs[7]  = '{C_MULH, C_MUL, C_DIV, C_REM, C_DIV, C_DIV, C_REM};
        logic [31:0] as[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'h8000_0000, 32'd5, 32'd5};
        logic [31:0] bs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd1, 32'd0, 32'd0};
        logic [31:0] rs[7]  = '{32'hFFFF_FFFE, 32'h0000_0001, 32'd14, 32'd2, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'd5};
        logic [31:0] r, er;
        logic [7:0]  f, ef;
        logic        dz, edz, ba;
        int          ed, ps;
        bit          to;
        for (int i = 0; i < 7; i++) begin
            do_op(cs[i], as[i], bs[i], 4'($urandom), 100, 1'b0, r, f, dz, ed, ps, ba, to);
            ref_op(cs[i], as[i], bs[i], flags_in[7:4], er, ef, edz);
            checks++;
            if (to) begin errors++; $display("FAIL directed%0d_timeout got timeout exp done", i); end
            checks++;
            if (r !== rs[i]) begin errors++; $display("FAIL directed%0d_result got %h exp %h", i, r, rs[i]); end
            checks++;
            if (f !== ef || dz !== edz) begin
                errors++;
                $display("FAIL directed%0d_flags got %h dz=%b exp %h dz=%b", i, f, dz, ef, edz);
            end
            checks++;
            if (ed !== ((bs[i] == 0) ? 1 : 33)) begin
                errors++;
                $display("FAIL directed%0d_latency got %0d exp %0d", i, ed, (bs[i] == 0) ? 1 : 33);
            end
        end
    endtask

    task automatic test_gnt_random();
        logic [31:0] r, er;
        logic [7:0]  f, ef;
        logic        dz, edz, ba;
        int          ed, ps;
        bit          to;
        do_op(C_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 4'h3, 50, 1'b1, r, f, dz, ed, ps, ba, to);
        ref_op(C_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 4'h3, er, ef, edz);
        checks++;
        if (to) begin errors++; $display("FAIL gnt_timeout got timeout exp done"); end
        checks++;
        if (ps !== 32) begin errors++; $display("FAIL gnt_passes got %0d exp 32", ps); end
        checks++;
        if (r !== er || r !== 32'h242D_2080) begin errors++; $display("FAIL gnt_result got %h exp %h", r, er); end
        checks++;
        if (f !== ef) begin errors++; $display("FAIL gnt_flags got %h exp %h", f, ef); end
        checks++;
        if (ba !== 1'b0) begin errors++; $display("FAIL gnt_start_in_done got busy=%b exp 0", ba); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic [7:0]  f;
        logic        dz, ba;
        int          ed, ps;
        bit          to;
        @(negedge clk);
        cmd = C_DIV; op_a = $urandom; op_b = 32'd13; flags_in = 8'hF0; start = 1'b1; alu_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, alu_req} !== 4'b0 || result !== 32'd0 || flags_out !== 8'd0) begin
            errors++;
            $display("FAIL midreset_outputs got ctrl=%b res=%h fl=%h exp 0", {busy, done, div_by_zero, alu_req},
                     result, flags_out);
        end
        checks++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 4'h0) begin
            errors++;
            $display("FAIL midreset_alu got %h/%h/%h exp 0/0/0", alu_a, alu_b, alu_op);
        end
        alu_gnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(C_DIV, 32'd9, 32'd3, 4'hA, 100, 1'b0, r, f, dz, ed, ps, ba, to);
        checks++;
        if (to || r !== 32'd3) begin errors++; $display("FAIL postreset_div got %h to=%b exp 3", r, to); end
        checks++;
        if (f !== 8'hA0) begin errors++; $display("FAIL postreset_flags got %h exp a0", f); end
    endtask

    task automatic test_random();
        logic [1:0]  c;
        logic [31:0] a, b, r, er;
        logic [7:0]  f, ef;
        logic        dz, edz, ba;
        int          ed, ps;
        bit          to;
        for (int i = 0; i < 16; i++) begin
            c = 2'($urandom);
            a = $urandom;
            case ($urandom_range(3))
                0:       b = 32'd0;
                1:       b = $urandom_range(15);
                default: b = $urandom;
            endcase
            do_op(c, a, b, 4'($urandom), 70, 1'b0, r, f, dz, ed, ps, ba, to);
            ref_op(c, a, b, flags_in[7:4], er, ef, edz);
            checks++;
            if (to || r !== er) begin
                errors++;
                $display("FAIL rand%0d_result cmd=%0d a=%h b=%h got %h exp %h", i, c, a, b, r, er);
            end
            checks++;
            if (f !== ef || dz !== edz) begin
                errors++;
                $display("FAIL rand%0d_flags got %h dz=%b exp %h dz=%b", i, f, dz, ef, edz);
            end
            checks++;
            if (ps !== (edz ? 0 : 32)) begin
                errors++;
                $display("FAIL rand%0d_passes got %0d exp %0d", i, ps, edz ? 0 : 32);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cmd = 2'd0; op_a = 32'd0; op_b = 32'd0;
        flags_in = 8'd0; alu_gnt = 1'b0; core_a = 32'd0; core_b = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_mul_basic();
        test_directed();
        test_gnt_random();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
